up_dn_cmd_gen: RTL

Upstream command stage for the 5-bit up/down counter. Conditions three raw push-buttons (up, down, load) and a 5-bit switch bank into clean, single-cycle, mutually exclusive `Up` / `Down` / `Load` strobes and a stable `IN` load value. Each button is synchronised, debounced and edge-detected; up and down auto-repeat while held. Outputs connect directly to the counter's `Up`, `Down`, `Load` and `IN` inputs, and share its `CLK`.

---
 rtl/up_dn_cmd_gen_pkg.sv | 20 ++
 rtl/up_dn_cmd_gen_if.sv | 23 ++
 rtl/up_dn_cmd_gen_btn_cond.sv | 78 +++++++
 rtl/up_dn_cmd_gen.sv | 65 ++++++
 4 files changed

// File: rtl/up_dn_cmd_gen_pkg.sv
// Shared constants and command encoding for the up/down counter command stage.
package up_dn_pkg;

   localparam int CNT_W               = 5;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 64;
   localparam int DEF_REPEAT_PERIOD   = 16;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_UP,
      CMD_DN,
      CMD_LD
   } cmd_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/up_dn_cmd_gen_if.sv
// Raw buttons/switches in, conditioned counter commands out.
interface up_dn_cmd_gen_if #(
   parameter int WIDTH = up_dn_pkg::CNT_W
);
   logic             BTN_UP;
   logic             BTN_DN;
   logic             BTN_LD;
   logic [WIDTH-1:0] SW;
   logic             Up;
   logic             Down;
   logic             Load;
   logic [WIDTH-1:0] IN;

   modport master (
      output BTN_UP, BTN_DN, BTN_LD, SW,
      input  Up, Down, Load, IN
   );

   modport slave (
      input  BTN_UP, BTN_DN, BTN_LD, SW,
      output Up, Down, Load, IN
   );
endinterface

// File: rtl/up_dn_cmd_gen_btn_cond.sv
// One button: 2-flop sync, debounce, press detect and optional auto-repeat.
// req_o is combinational from registered state; the top registers the arbitrated strobe.
module btn_cond
   import up_dn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic req_o
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int RC_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RC_DELAY  = RC_W'(REPEAT_DELAY);
   localparam logic [RC_W-1:0] RC_PERIOD = RC_W'(REPEAT_PERIOD);
   localparam logic [RC_W-1:0] RC_MAX    = {RC_W{1'b1}};

   logic            s1_q, s2_q;
   logic            db_q, db_d, db_prev_q;
   logic            rep_q, rep_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic [RC_W-1:0] rcnt_q, rcnt_d;
   logic            press, rep_hit;

   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (s2_q != db_q) begin
         if (cnt_q == DB_LAST) db_d = s2_q;
         else                  cnt_d = cnt_q + 1'b1;
      end
   end

   assign press   = db_q & ~db_prev_q;
   // rep_q selects the initial delay vs. the steady repeat period
   assign rep_hit = REPEAT_EN && db_q && (rcnt_q == (rep_q ? RC_PERIOD : RC_DELAY));
   assign req_o   = press | rep_hit;

   always_comb begin
      rcnt_d = '0;
      rep_d  = 1'b0;
      if (REPEAT_EN && db_q) begin
         if (rep_hit) begin
            rcnt_d = RC_W'(1);
            rep_d  = 1'b1;
         end else begin
            rcnt_d = (rcnt_q == RC_MAX) ? rcnt_q : rcnt_q + 1'b1;
            rep_d  = rep_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
         rcnt_q    <= '0;
         rep_q     <= 1'b0;
      end else begin
         s1_q      <= btn_i;
         s2_q      <= s1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
         rcnt_q    <= rcnt_d;
         rep_q     <= rep_d;
      end
   end

endmodule

// File: rtl/up_dn_cmd_gen.sv
// Command stage: conditions three buttons and a switch bank into exclusive Up/Down/Load strobes
// with a registered load value; fixed priority Load > Down > Up, losers are dropped.
module up_dn_cmd_gen
   import up_dn_pkg::*;
#(
   parameter int WIDTH           = CNT_W,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input logic            CLK,
   input logic            RST,
   up_dn_cmd_gen_if.slave bus
);
   logic             up_req, dn_req, ld_req;
   logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
   logic [WIDTH-1:0] in_q, in_d;
   logic             up_q, dn_q, ld_q;
   cmd_t             cmd_d;

   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
              .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
      u_up (.clk_i(CLK), .rst_i(RST), .btn_i(bus.BTN_UP), .req_o(up_req));

   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
              .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
      u_dn (.clk_i(CLK), .rst_i(RST), .btn_i(bus.BTN_DN), .req_o(dn_req));

   btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
              .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
      u_ld (.clk_i(CLK), .rst_i(RST), .btn_i(bus.BTN_LD), .req_o(ld_req));

   always_comb begin
      cmd_d = CMD_NONE;
      if      (ld_req) cmd_d = CMD_LD;
      else if (dn_req) cmd_d = CMD_DN;
      else if (up_req) cmd_d = CMD_UP;
   end

   assign in_d = (cmd_d == CMD_LD) ? sw_s2_q : in_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sw_s1_q <= '0;
         sw_s2_q <= '0;
         in_q    <= '0;
         up_q    <= 1'b0;
         dn_q    <= 1'b0;
         ld_q    <= 1'b0;
      end else begin
         sw_s1_q <= bus.SW;
         sw_s2_q <= sw_s1_q;
         in_q    <= in_d;
         up_q    <= (cmd_d == CMD_UP);
         dn_q    <= (cmd_d == CMD_DN);
         ld_q    <= (cmd_d == CMD_LD);
      end
   end

   assign bus.Up   = up_q;
   assign bus.Down = dn_q;
   assign bus.Load = ld_q;
   assign bus.IN   = in_q;

endmodule
